// File: rtl/tile_pkg.sv
// Shared types for the tile buffer controller: pixel/quad layout and FSM states.
package tile_pkg;

    typedef struct packed {
        logic [47:0] color;
        logic [23:0] depth;
    } pixel_t;

    typedef pixel_t [3:0] quad_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RASTER,
        ST_RESOLVE,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/tile_beat_fifo.sv
// Resolve beat FIFO: power-of-two depth, registered full/empty flags, occupancy output.
module tile_beat_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_full, r_empty;
    logic             w_push, w_pop;
    logic [CW-1:0]    w_next_count;

    assign w_push       = i_push && !r_full;
    assign w_pop        = i_pop && !r_empty;
    assign w_next_count = r_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= w_next_count;
            r_full  <= (w_next_count == CW'(DEPTH));
            r_empty <= (w_next_count == '0);
        end
    end

    // Storage needs no reset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    assign o_data  = r_mem[r_rptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: rtl/tile_buffer_ctrl.sv
// Tile buffer controller: clear, raster write-through, then resolve the tile out as quad beats.
// Optional stall counter output enabled by defining TILE_BUFFER_CTRL_PERF_EN.
module tile_buffer_ctrl
    import tile_pkg::*;
#(
    parameter int POS_ADDRW   = 8,
    parameter int TILE_WIDTH  = 128,
    parameter int TILE_HEIGHT = 64,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_tile_start,
    input  logic [47:0]          i_clear_color,
    input  logic [23:0]          i_clear_depth,
    output logic                 o_busy,
    input  logic                 r_valid,
    output logic                 r_ready,
    input  logic [POS_ADDRW-1:0] r_x,
    input  logic [POS_ADDRW-1:0] r_y,
    input  quad_t                r_data,
    input  logic [3:0]           r_mask,
    input  logic                 r_last,
    output logic [POS_ADDRW-1:0] tb_write_x,
    output logic [POS_ADDRW-1:0] tb_write_y,
    output quad_t                tb_pixel_data,
    output logic [3:0]           tb_write_mask,
    output logic                 tb_write_valid,
    output logic [POS_ADDRW-1:0] tb_read_x,
    output logic [POS_ADDRW-1:0] tb_read_y,
    output logic                 tb_read_valid,
    input  quad_t                tb_read_data,
    input  logic                 tb_read_data_valid,
    input  logic                 tb_ready,
    output logic                 tb_clear,
    output logic [47:0]          tb_clear_color,
    output logic [23:0]          tb_clear_depth,
    input  logic                 tb_clear_done,
    output quad_t                o_beat_data,
    output logic                 o_beat_valid,
    input  logic                 i_beat_ready,
`ifdef TILE_BUFFER_CTRL_PERF_EN
    output logic [31:0]          o_stall_cycles,
`endif
    output logic                 o_beat_last
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int QW = $bits(quad_t);

    state_t                r_state, w_next;
    logic [POS_ADDRW-1:0]  r_rx, r_ry;
    logic [CW-1:0]         r_inflight;
    logic                  r_pend_last, r_last_acc, r_tb_clear;
    logic [47:0]           r_clr_color;
    logic [23:0]           r_clr_depth;
    logic                  w_start, w_rd_last, w_can_issue, w_acc_last, w_pop;
    logic                  w_empty, w_full;
    logic [CW-1:0]         w_count;
    logic [QW:0]           w_fifo_q;

    assign w_start     = (r_state == ST_IDLE) && i_tile_start;
    assign w_rd_last   = (r_rx == POS_ADDRW'(TILE_WIDTH - 4)) && (r_ry == POS_ADDRW'(TILE_HEIGHT - 1));
    // Count beats still to land so a read never targets a slot that might not exist.
    assign w_can_issue = ({1'b0, w_count} + {1'b0, r_inflight}) < (CW + 1)'(FIFO_DEPTH);
    assign w_acc_last  = r_valid && r_ready && r_last;
    assign w_pop       = o_beat_valid && i_beat_ready;

    always_comb begin
        w_next         = r_state;
        r_ready        = 1'b0;
        tb_write_valid = 1'b0;
        tb_write_x     = '0;
        tb_write_y     = '0;
        tb_pixel_data  = '0;
        tb_write_mask  = '0;
        tb_read_valid  = 1'b0;
        case (r_state)
            ST_IDLE:    if (i_tile_start) w_next = ST_CLEAR;
            ST_CLEAR:   if (tb_clear_done) w_next = ST_RASTER;
            ST_RASTER: begin
                r_ready        = tb_ready;
                tb_write_valid = r_valid && tb_ready;
                tb_write_x     = r_x;
                tb_write_y     = r_y;
                tb_pixel_data  = r_data;
                tb_write_mask  = r_mask;
                if (w_acc_last) w_next = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                tb_read_valid = w_can_issue;
                if (w_can_issue && w_rd_last) w_next = ST_DRAIN;
            end
            ST_DRAIN:   if (w_empty && r_inflight == '0 && r_last_acc) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_rx        <= '0;
            r_ry        <= '0;
            r_inflight  <= '0;
            r_pend_last <= 1'b0;
            r_last_acc  <= 1'b0;
            r_tb_clear  <= 1'b0;
            r_clr_color <= '0;
            r_clr_depth <= '0;
        end else begin
            r_state     <= w_next;
            r_tb_clear  <= w_start;
            r_pend_last <= tb_read_valid && w_rd_last;
            r_inflight  <= r_inflight + CW'(tb_read_valid) - CW'(tb_read_data_valid);
            if (w_start) begin
                r_clr_color <= i_clear_color;
                r_clr_depth <= i_clear_depth;
                r_last_acc  <= 1'b0;
                r_rx        <= '0;
                r_ry        <= '0;
            end else if (tb_read_valid) begin
                if (w_rd_last) begin
                    r_rx <= '0;
                    r_ry <= '0;
                end else if (r_rx == POS_ADDRW'(TILE_WIDTH - 4)) begin
                    r_rx <= '0;
                    r_ry <= r_ry + POS_ADDRW'(1);
                end else begin
                    r_rx <= r_rx + POS_ADDRW'(4);
                end
            end
            if (w_pop && o_beat_last) r_last_acc <= 1'b1;
        end
    end

    // Read latency is exactly one cycle, so the last-read tag lines up with the returning beat.
    tile_beat_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(QW + 1)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (tb_read_data_valid),
        .i_data  ({r_pend_last, tb_read_data}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_q),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign o_busy         = (r_state != ST_IDLE);
    assign tb_read_x      = r_rx;
    assign tb_read_y      = r_ry;
    assign tb_clear       = r_tb_clear;
    assign tb_clear_color = r_clr_color;
    assign tb_clear_depth = r_clr_depth;
    assign o_beat_valid   = !w_empty;
    assign o_beat_data    = w_empty ? '0 : quad_t'(w_fifo_q[QW-1:0]);
    assign o_beat_last    = !w_empty && w_fifo_q[QW];

`ifdef TILE_BUFFER_CTRL_PERF_EN
    logic [31:0] r_stall_cnt;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                                    r_stall_cnt <= '0;
        else if (w_start)                                             r_stall_cnt <= '0;
        else if (o_beat_valid && !i_beat_ready && r_stall_cnt != '1)  r_stall_cnt <= r_stall_cnt + 32'd1;
    end
    assign o_stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_tile_buffer_ctrl.sv
// Bench for tile_buffer_ctrl: directed tiles, tile-buffer read model, scoreboard of resolve beats.
module tb_tile_buffer_ctrl;
    import tile_pkg::*;

    localparam int PW = 8, TW = 128, TH = 64, FD = 4;
    localparam int NQ = (TW / 4) * TH;

    logic          clk = 1'b0;
    logic          rstn;
    logic          i_tile_start;
    logic [47:0]   i_clear_color;
    logic [23:0]   i_clear_depth;
    logic          o_busy;
    logic          r_valid, r_ready, r_last;
    logic [PW-1:0] r_x, r_y;
    quad_t         r_data;
    logic [3:0]    r_mask;
    logic [PW-1:0] tb_write_x, tb_write_y, tb_read_x, tb_read_y;
    quad_t         tb_pixel_data, tb_read_data, o_beat_data;
    logic [3:0]    tb_write_mask;
    logic          tb_write_valid, tb_read_valid, tb_read_data_valid, tb_ready;
    logic          tb_clear, tb_clear_done;
    logic [47:0]   tb_clear_color;
    logic [23:0]   tb_clear_depth;
    logic          o_beat_valid, i_beat_ready, o_beat_last;
`ifdef TILE_BUFFER_CTRL_PERF_EN
    logic [31:0]   o_stall_cycles;
`endif

    always #5 clk = ~clk;

    tile_buffer_ctrl #(.POS_ADDRW(PW), .TILE_WIDTH(TW), .TILE_HEIGHT(TH), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rstn(rstn), .i_tile_start(i_tile_start), .i_clear_color(i_clear_color),
        .i_clear_depth(i_clear_depth), .o_busy(o_busy), .r_valid(r_valid), .r_ready(r_ready),
        .r_x(r_x), .r_y(r_y), .r_data(r_data), .r_mask(r_mask), .r_last(r_last),
        .tb_write_x(tb_write_x), .tb_write_y(tb_write_y), .tb_pixel_data(tb_pixel_data),
        .tb_write_mask(tb_write_mask), .tb_write_valid(tb_write_valid), .tb_read_x(tb_read_x),
        .tb_read_y(tb_read_y), .tb_read_valid(tb_read_valid), .tb_read_data(tb_read_data),
        .tb_read_data_valid(tb_read_data_valid), .tb_ready(tb_ready), .tb_clear(tb_clear),
        .tb_clear_color(tb_clear_color), .tb_clear_depth(tb_clear_depth),
        .tb_clear_done(tb_clear_done), .o_beat_data(o_beat_data), .o_beat_valid(o_beat_valid),
        .i_beat_ready(i_beat_ready),
`ifdef TILE_BUFFER_CTRL_PERF_EN
        .o_stall_cycles(o_stall_cycles),
`endif
        .o_beat_last(o_beat_last)
    );

    typedef struct { quad_t d; logic last; } exp_t;
    exp_t sb[$];
    exp_t m_e;

    int n_chk = 0, n_pass = 0;
    int rd_n, issued, popped, maxout, clr_pulses, stalls, n_last;
    logic [47:0] exp_color;
    logic [23:0] exp_depth;
    logic  hold;
    quad_t hold_d;

    function automatic quad_t pat(input logic [7:0] x, input logic [7:0] y);
        quad_t q;
        logic [7:0] kb;
        for (int k = 0; k < 4; k++) begin
            kb   = 8'(k);
            q[k] = pixel_t'({x, y, kb, 8'h5A, x ^ y, 8'h3C, y, ~x, kb});
        end
        return q;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic chk_q(input string nm, input quad_t got, input quad_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Tile-buffer read model: one-cycle latency, data derived from the read address.
    initial begin
        logic rv;
        logic [7:0] rx, ry;
        tb_read_data_valid = 1'b0;
        tb_read_data       = '0;
        forever begin
            @(negedge clk);
            rv = rstn && tb_read_valid;
            rx = tb_read_x;
            ry = tb_read_y;
            @(posedge clk);
            #1;
            tb_read_data_valid = rv;
            tb_read_data       = rv ? pat(rx, ry) : '0;
        end
    end

    // Monitor: pops the scoreboard on every accepted beat and checks side invariants.
    always @(negedge clk) begin
        if (!rstn) begin
            hold = 1'b0;
        end else begin
            if (tb_clear) begin
                clr_pulses++;
                chk("clear_color", tb_clear_color, exp_color);
                chk("clear_depth", tb_clear_depth, exp_depth);
            end
            if (tb_write_valid || tb_read_valid)
                chk("wr_rd_exclusive", tb_write_valid && tb_read_valid, 0);
            if (tb_read_valid) begin
                chk("read_x", tb_read_x, (rd_n % (TW / 4)) * 4);
                chk("read_y", tb_read_y, rd_n / (TW / 4));
                rd_n++;
                issued++;
            end
            if (hold) begin
                chk("hold_valid", o_beat_valid, 1);
                chk_q("hold_data", o_beat_data, hold_d);
            end
            if (o_beat_valid && !i_beat_ready) begin
                stalls++;
                hold   = 1'b1;
                hold_d = o_beat_data;
            end else begin
                hold = 1'b0;
            end
            if (o_beat_valid && i_beat_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    m_e = sb.pop_front();
                    chk_q("beat_data", o_beat_data, m_e.d);
                    chk("beat_last", o_beat_last, m_e.last);
                end
                popped++;
                if (o_beat_last) n_last++;
            end
            if (issued - popped > maxout) maxout = issued - popped;
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_r_ready"}, r_ready, 0);
        chk({tag, "_tb_clear"}, tb_clear, 0);
        chk({tag, "_clear_color"}, tb_clear_color, 0);
        chk({tag, "_clear_depth"}, tb_clear_depth, 0);
        chk({tag, "_wr_valid"}, tb_write_valid, 0);
        chk({tag, "_rd_valid"}, tb_read_valid, 0);
        chk({tag, "_rd_xy"}, {tb_read_x, tb_read_y}, 0);
        chk({tag, "_beat_valid"}, o_beat_valid, 0);
        chk({tag, "_beat_last"}, o_beat_last, 0);
        chk({tag, "_beat_data"}, o_beat_data != '0, 0);
    endtask

    task automatic start_tile(input logic [47:0] c, input logic [23:0] d);
        rd_n = 0; issued = 0; popped = 0; maxout = 0;
        clr_pulses = 0; stalls = 0; n_last = 0;
        exp_color = c; exp_depth = d;
        i_clear_color = c;
        i_clear_depth = d;
        i_tile_start  = 1'b1;
        step();
        i_tile_start  = 1'b0;
        i_clear_color = '0;
        i_clear_depth = '0;
        r_valid = 1'b1;
        tb_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("clear_r_ready", r_ready, 0);
            chk("clear_no_write", tb_write_valid, 0);
            chk("clear_no_read", tb_read_valid, 0);
            chk("clear_busy", o_busy, 1);
            step();
            i_tile_start = (i == 2);
        end
        i_tile_start = 1'b0;
        @(negedge clk);
        chk("clear_pulses", clr_pulses, 1);
        step();
        r_valid = 1'b0;
        tb_clear_done = 1'b1;
        step();
        tb_clear_done = 1'b0;
    endtask

    task automatic raster_tile();
        r_x = 8'd2; r_y = 8'd4; r_mask = 4'b1010; r_data = pat(8'd9, 8'd9);
        r_valid = 1'b1; tb_ready = 1'b1;
        @(negedge clk);
        chk("raster_r_ready", r_ready, 1);
        chk("raster_wr_valid", tb_write_valid, 1);
        chk("raster_wr_xy", {tb_write_x, tb_write_y}, {8'd2, 8'd4});
        chk("raster_wr_mask", tb_write_mask, 4'b1010);
        chk_q("raster_wr_data", tb_pixel_data, pat(8'd9, 8'd9));
        step();
        tb_ready = 1'b0;
        @(negedge clk);
        chk("bp_r_ready", r_ready, 0);
        chk("bp_wr_valid", tb_write_valid, 0);
        step();
        for (int y = 0; y < TH; y++)
            for (int x = 0; x < TW; x += 4) begin
                m_e.d    = pat(8'(x), 8'(y));
                m_e.last = (x == TW - 4) && (y == TH - 1);
                sb.push_back(m_e);
            end
        tb_ready = 1'b1; r_x = 8'd126; r_y = 8'd62; r_mask = 4'b1111; r_last = 1'b1;
        r_data = pat(8'd126, 8'd62);
        @(negedge clk);
        chk("last_wr_valid", tb_write_valid, 1);
        chk("last_wr_xy", {tb_write_x, tb_write_y}, {8'd126, 8'd62});
        step();
        r_valid = 1'b0; r_last = 1'b0;
    endtask

    task automatic run_resolve(input int stall_at, input int reset_at, output bit did_reset);
        int  cyc;
        bit  stalled;
        cyc = 0; stalled = 0; did_reset = 0;
        while (o_busy && cyc < 20000) begin
            if (!stalled && stall_at >= 0 && popped >= stall_at) begin
                i_beat_ready = 1'b0;
                step(50);
                i_beat_ready = 1'b1;
                stalled = 1;
            end
            if (reset_at >= 0 && popped >= reset_at) begin
                rstn = 1'b0;
                @(negedge clk);
                check_zero("midreset");
                step(3);
                rstn = 1'b1;
                sb.delete();
                step();
                @(negedge clk);
                chk("post_reset_idle", o_busy, 0);
                did_reset = 1;
                return;
            end
            step();
            cyc++;
        end
        chk("tile_done_in_time", cyc < 20000, 1);
    endtask

    initial begin
        bit rst_hit;
        rstn = 1'b0; i_tile_start = 1'b0; i_clear_color = '0; i_clear_depth = '0;
        r_valid = 1'b0; r_x = '0; r_y = '0; r_data = '0; r_mask = '0; r_last = 1'b0;
        tb_ready = 1'b0; tb_clear_done = 1'b0; i_beat_ready = 1'b1;
        rd_n = 0; issued = 0; popped = 0; maxout = 0; clr_pulses = 0; stalls = 0; n_last = 0;
        hold = 1'b0; hold_d = '0; exp_color = '0; exp_depth = '0;
        step(2);
        @(negedge clk);
        check_zero("reset");
        step();
        rstn = 1'b1;
        step();

        // Tile 1: full tile with a 50-cycle output stall
        start_tile(48'h123456789ABC, 24'hFFFFFF);
        raster_tile();
        run_resolve(100, -1, rst_hit);
        chk("t1_beats", popped, NQ);
        chk("t1_last_count", n_last, 1);
        chk("t1_sb_empty", sb.size(), 0);
        chk("t1_outstanding", maxout, FD);
        chk("t1_stall_cycles", stalls, 50);
`ifdef TILE_BUFFER_CTRL_PERF_EN
        chk("t1_o_stall_cycles", o_stall_cycles, 50);
`endif

        // Tile 2: reset lands in the middle of resolve
        start_tile(48'hA5A5_0000_5A5A, 24'h00C0DE);
        raster_tile();
        run_resolve(-1, 300, rst_hit);
        chk("t2_reset_hit", rst_hit, 1);

        // Tile 3: normal tile after the reset
        start_tile(48'h0000_1111_2222, 24'h333333);
        raster_tile();
        run_resolve(-1, -1, rst_hit);
        chk("t3_beats", popped, NQ);
        chk("t3_last_count", n_last, 1);
        chk("t3_sb_empty", sb.size(), 0);
        chk("t3_outstanding_le_depth", maxout <= FD, 1);
        chk("t3_stall_cycles", stalls, 0);
`ifdef TILE_BUFFER_CTRL_PERF_EN
        chk("t3_o_stall_cycles", o_stall_cycles, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
